// File: rtl/mlp_train_seq.sv
// Training-run sequencer for a small perceptron/MLP datapath.
// Walks the sample memory one sample at a time, launches a forward pass,
// turns the returned score into a saturated hinge error, counts
// misclassifications and issues one update strobe per sample. Runs repeat
// per epoch until an epoch has no misses or the epoch limit is reached.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start, abort      : run control (start sampled in IDLE only)
//   learn_en          : 0 suppresses the learn strobe (evaluate only)
//   n_samples         : samples per epoch
//   max_epochs        : epoch limit
//   mem_rd_en/addr    : sample read request; mem_rd_data returns {label, x}
//   x_out             : current sample to the datapath
//   fwd_start/done    : forward-pass handshake; score valid with fwd_done
//   learn, err        : update strobe and error for the update block
//   busy, done        : run in progress / one-cycle completion pulse
//   timeout           : sticky, forward pass never completed
//   epoch_cnt         : completed epochs
//   miss_cnt          : misclassifications in the current or last epoch
module mlp_train_seq #(
    parameter int unsigned W       = 8,
    parameter int unsigned SCORE_W = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned EPOCH_W = 8,
    parameter int unsigned TGT     = 32,
    parameter int unsigned FWD_TMO = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      learn_en,
    input  logic [ADDR_W:0]           n_samples,
    input  logic [EPOCH_W-1:0]        max_epochs,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [16:0]               mem_rd_data,
    output logic [15:0]               x_out,
    output logic                      fwd_start,
    input  logic                      fwd_done,
    input  logic signed [SCORE_W-1:0] score,
    output logic                      learn,
    output logic signed [W-1:0]       err,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout,
    output logic [EPOCH_W-1:0]        epoch_cnt,
    output logic [ADDR_W:0]           miss_cnt
);

    localparam int unsigned AW1    = ADDR_W + 1;
    localparam int unsigned DIFF_W = SCORE_W + 1;
    localparam int unsigned TMO_W  = (FWD_TMO > 1) ? $clog2(FWD_TMO + 1) : 1;

    localparam logic signed [DIFF_W-1:0] TGT_P  = DIFF_W'(TGT);
    localparam logic signed [DIFF_W-1:0] TGT_N  = -TGT_P;
    localparam logic signed [DIFF_W-1:0] ERR_HI = DIFF_W'((1 << (W - 1)) - 1);
    localparam logic signed [DIFF_W-1:0] ERR_LO = ~ERR_HI;

    typedef enum logic [2:0] {
        IDLE, FETCH, RDWAIT, FWD, WAITF, UPDATE, NEXT, FIN
    } state_t;

    state_t state_q, state_nxt;

    logic                      label_q, label_nxt;
    logic [TMO_W-1:0]          tmo_cnt_q, tmo_cnt_nxt, tmo_inc;
    logic [ADDR_W-1:0]         addr_nxt;
    logic [15:0]               x_nxt;
    logic signed [W-1:0]       err_nxt;
    logic [EPOCH_W-1:0]        epoch_nxt, epoch_inc;
    logic [AW1-1:0]            miss_nxt;
    logic                      timeout_nxt;
    logic                      rd_en_nxt, fwd_start_nxt, learn_nxt, done_nxt, busy_nxt;
    logic                      addr_last;

    logic signed [DIFF_W-1:0]  score_x, tgt_s, diff;
    logic signed [W-1:0]       err_sat, err_c;
    logic                      hinge, miss_c;

    assign tmo_inc   = tmo_cnt_q + TMO_W'(1);
    assign epoch_inc = epoch_cnt + EPOCH_W'(1);
    assign addr_last = (AW1'(mem_addr) + AW1'(1)) >= n_samples;

    // Error and miss classification of the returned score against the latched label
    always_comb begin
        score_x = {score[SCORE_W-1], score};
        tgt_s   = label_q ? TGT_P : TGT_N;
        diff    = tgt_s - score_x;
        if (diff > ERR_HI) begin
            err_sat = W'(ERR_HI);
        end else if (diff < ERR_LO) begin
            err_sat = W'(ERR_LO);
        end else begin
            err_sat = W'(diff);
        end
        // Hinge: a confidently correct score produces no update
        hinge  = label_q ? (score_x >= TGT_P) : (score_x <= TGT_N);
        err_c  = hinge ? '0 : err_sat;
        miss_c = label_q ? (score[SCORE_W-1] || (score == '0))
                         : (!score[SCORE_W-1] && (score != '0));
    end

    // Next-state and next-value logic
    always_comb begin
        state_nxt   = state_q;
        label_nxt   = label_q;
        tmo_cnt_nxt = tmo_cnt_q;
        addr_nxt    = mem_addr;
        x_nxt       = x_out;
        err_nxt     = err;
        epoch_nxt   = epoch_cnt;
        miss_nxt    = miss_cnt;
        timeout_nxt = timeout;

        if (abort && (state_q != IDLE)) begin
            // Abort drops straight to IDLE and leaves every counter untouched
            state_nxt = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        if ((n_samples != '0) && (max_epochs != '0)) begin
                            state_nxt   = FETCH;
                            addr_nxt    = '0;
                            epoch_nxt   = '0;
                            miss_nxt    = '0;
                            timeout_nxt = 1'b0;
                        end else begin
                            state_nxt = FIN;
                        end
                    end
                end
                FETCH: begin
                    state_nxt = RDWAIT;
                end
                RDWAIT: begin
                    x_nxt     = mem_rd_data[15:0];
                    label_nxt = mem_rd_data[16];
                    state_nxt = FWD;
                end
                FWD: begin
                    tmo_cnt_nxt = '0;
                    state_nxt   = WAITF;
                end
                WAITF: begin
                    if (fwd_done) begin
                        err_nxt = err_c;
                        if (miss_c && (miss_cnt != '1)) begin
                            miss_nxt = miss_cnt + AW1'(1);
                        end
                        state_nxt = UPDATE;
                    end else begin
                        tmo_cnt_nxt = tmo_inc;
                        if (tmo_inc == TMO_W'(FWD_TMO)) begin
                            timeout_nxt = 1'b1;
                            state_nxt   = FIN;
                        end
                    end
                end
                UPDATE: begin
                    state_nxt = NEXT;
                end
                NEXT: begin
                    if (addr_last) begin
                        epoch_nxt = epoch_inc;
                        if ((miss_cnt == '0) || (epoch_inc == max_epochs)) begin
                            state_nxt = FIN;
                        end else begin
                            addr_nxt  = '0;
                            miss_nxt  = '0;
                            state_nxt = FETCH;
                        end
                    end else begin
                        addr_nxt  = mem_addr + ADDR_W'(1);
                        state_nxt = FETCH;
                    end
                end
                FIN: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        // Strobes are registered from the next state so they align with it
        rd_en_nxt     = (state_nxt == FETCH);
        fwd_start_nxt = (state_nxt == FWD);
        learn_nxt     = (state_nxt == UPDATE) && learn_en;
        done_nxt      = (state_nxt == FIN);
        busy_nxt      = (state_nxt != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            label_q   <= 1'b0;
            tmo_cnt_q <= '0;
            mem_addr  <= '0;
            x_out     <= '0;
            err       <= '0;
            epoch_cnt <= '0;
            miss_cnt  <= '0;
            timeout   <= 1'b0;
            mem_rd_en <= 1'b0;
            fwd_start <= 1'b0;
            learn     <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            label_q   <= label_nxt;
            tmo_cnt_q <= tmo_cnt_nxt;
            mem_addr  <= addr_nxt;
            x_out     <= x_nxt;
            err       <= err_nxt;
            epoch_cnt <= epoch_nxt;
            miss_cnt  <= miss_nxt;
            timeout   <= timeout_nxt;
            mem_rd_en <= rd_en_nxt;
            fwd_start <= fwd_start_nxt;
            learn     <= learn_nxt;
            done      <= done_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_mlp_train_seq.sv
// Bench for mlp_train_seq: sample memory and forward-pass responders plus a
// per-run reference model of the whole training run.
module tb_mlp_train_seq;

    localparam int W       = 8;
    localparam int SCORE_W = 16;
    localparam int ADDR_W  = 4;
    localparam int EPOCH_W = 8;
    localparam int TGT     = 32;
    localparam int FWD_TMO = 255;
    localparam int ERR_HI  = (1 << (W - 1)) - 1;
    localparam int ERR_LO  = -(1 << (W - 1));
    localparam int MISS_MAX = (1 << (ADDR_W + 1)) - 1;

    logic                      clk;
    logic                      rst, start, abort, learn_en;
    logic [ADDR_W:0]           n_samples;
    logic [EPOCH_W-1:0]        max_epochs;
    logic                      mem_rd_en;
    logic [ADDR_W-1:0]         mem_addr;
    logic [16:0]               mem_rd_data;
    logic [15:0]               x_out;
    logic                      fwd_start, fwd_done;
    logic signed [SCORE_W-1:0] score;
    logic                      learn;
    logic signed [W-1:0]       err;
    logic                      busy, done, timeout;
    logic [EPOCH_W-1:0]        epoch_cnt;
    logic [ADDR_W:0]           miss_cnt;

    mlp_train_seq #(
        .W(W), .SCORE_W(SCORE_W), .ADDR_W(ADDR_W), .EPOCH_W(EPOCH_W),
        .TGT(TGT), .FWD_TMO(FWD_TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .learn_en(learn_en),
        .n_samples(n_samples), .max_epochs(max_epochs),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .x_out(x_out), .fwd_start(fwd_start), .fwd_done(fwd_done), .score(score),
        .learn(learn), .err(err), .busy(busy), .done(done), .timeout(timeout),
        .epoch_cnt(epoch_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Environment state
    logic [16:0]     mem [16];
    int              score_seq[$];
    int              fwd_idx, fwd_wait, fwd_delay, hang_k, cur_score;
    logic            rd_pend;
    logic [ADDR_W-1:0] rd_addr;
    logic            upd_now;
    int              cyc;

    // Reference results
    int exp_x[$];
    int exp_err[$];
    int exp_ep, exp_miss, exp_k;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int score_at(input int k);
        if (k < score_seq.size()) return score_seq[k];
        return 0;
    endfunction

    function automatic int ref_err(input bit lab, input int s);
        int d;
        if (lab && (s >= TGT)) return 0;
        if (!lab && (s <= -TGT)) return 0;
        d = (lab ? TGT : -TGT) - s;
        if (d > ERR_HI) return ERR_HI;
        if (d < ERR_LO) return ERR_LO;
        return d;
    endfunction

    // Whole-run model: epochs of n samples, stopping on a clean epoch, the
    // epoch limit, or after stop_k forward passes (hang/abort/reset point).
    task automatic ref_run(input int n, input int me, input int stop_k);
        int k, ep, ms, s;
        bit stop, lab, wrong;
        exp_x.delete();
        exp_err.delete();
        k = 0; ep = 0; ms = 0; stop = 1'b0;
        while (!stop) begin
            ms = 0;
            for (int a = 0; a < n && !stop; a++) begin
                if (k == stop_k) begin
                    stop = 1'b1;
                end else begin
                    lab = mem[a][16];
                    s = score_at(k);
                    exp_x.push_back(int'(mem[a][15:0]));
                    exp_err.push_back(ref_err(lab, s));
                    wrong = lab ? (s <= 0) : (s > 0);
                    if (wrong && ms < MISS_MAX) ms++;
                    k++;
                end
            end
            if (!stop) begin
                ep++;
                if (ms == 0 || ep == me) stop = 1'b1;
            end
        end
        exp_ep = ep; exp_miss = ms; exp_k = k;
    endtask

    // One clock: sample point is the falling edge; responders update inputs here
    task automatic tick();
        @(negedge clk);
        cyc++;
        upd_now = fwd_done;
        mem_rd_data = rd_pend ? mem[rd_addr] : 17'($urandom);
        rd_pend = mem_rd_en;
        rd_addr = mem_addr;
        fwd_done = 1'b0;
        score = SCORE_W'($urandom);
        if (fwd_wait == 0) begin
            fwd_done = 1'b1;
            score = SCORE_W'(cur_score);
            fwd_wait = -1;
        end else if (fwd_wait > 0) begin
            fwd_wait--;
        end
        if (fwd_start) begin
            cur_score = score_at(fwd_idx);
            fwd_wait = (fwd_idx == hang_k) ? -1 : fwd_delay;
            fwd_idx++;
        end
    endtask

    task automatic fill_mem(input int lab_mode);
        for (int i = 0; i < 16; i++) begin
            mem[i] = 17'($urandom);
            if (lab_mode == 0) mem[i][16] = 1'b0;
            if (lab_mode == 1) mem[i][16] = 1'b1;
        end
    endtask

    task automatic fill_scores(input int cnt, input int lo, input int hi);
        score_seq.delete();
        for (int i = 0; i < cnt; i++) score_seq.push_back(lo + int'($urandom_range(hi - lo)));
    endtask

    // mode 0: run to completion (h>=0 withholds fwd_done of pass h -> timeout)
    // mode 1: abort while waiting on withheld pass h
    // mode 2: reset during the update cycle of pass h
    task automatic run_case(input string tag, input int n, input int me, input bit le,
                            input int d, input int h, input int mode);
        int pi, nlearn, done_cyc, wc, exp_done, act;
        bit fin, stab;
        fwd_idx = 0; fwd_wait = -1; fwd_delay = d;
        hang_k = (mode == 2) ? -1 : h;
        ref_run(n, me, (mode == 2) ? h + 1 : h);
        n_samples = (ADDR_W + 1)'(n);
        max_epochs = EPOCH_W'(me);
        learn_en = le;
        start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        chk({tag, "/busy_at_fetch"}, busy, 1);
        chk({tag, "/rd_en_at_fetch"}, mem_rd_en, 1);
        pi = 0; nlearn = 0; done_cyc = -1; wc = 0; fin = 1'b0; stab = 1'b0;
        while (!fin && cyc < 4000) begin
            if (stab) begin
                chk({tag, "/x_hold"}, x_out, exp_x[pi-1]);
                chk({tag, "/err_hold"}, err, exp_err[pi-1]);
            end
            stab = 1'b0;
            if (upd_now) begin
                if (pi < exp_k) begin
                    chk({tag, "/learn"}, learn, le);
                    chk({tag, "/x_out"}, x_out, exp_x[pi]);
                    chk({tag, "/err"}, err, exp_err[pi]);
                    stab = 1'b1;
                end else begin
                    chk({tag, "/extra_pass"}, pi, exp_k);
                end
                pi++;
            end else if (learn) begin
                chk({tag, "/stray_learn"}, learn, 0);
            end
            if (learn) nlearn++;
            if (done) begin
                done_cyc = cyc;
                fin = 1'b1;
            end else if (mode == 1 && fwd_idx == h + 1) begin
                wc++;
                if (wc == 3) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    fin = 1'b1;
                end
            end else if (mode == 2 && upd_now && pi == h + 1) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                fin = 1'b1;
            end
            if (!fin) begin
                start = (cyc == 4);
                tick();
                start = 1'b0;
            end
        end
        chk({tag, "/passes"}, pi, exp_k);
        chk({tag, "/learn_count"}, nlearn, le ? exp_k : 0);
        if (mode == 0) begin
            exp_done = (h < 0) ? 1 + (6 + d) * exp_k : 1 + (6 + d) * h + 3 + FWD_TMO;
            chk({tag, "/done_cycle"}, done_cyc, exp_done);
            chk({tag, "/epoch_cnt"}, epoch_cnt, exp_ep);
            chk({tag, "/miss_cnt"}, miss_cnt, exp_miss);
            chk({tag, "/timeout"}, timeout, (h >= 0) ? 1 : 0);
            tick();
            chk({tag, "/done_one_cycle"}, done, 0);
            chk({tag, "/busy_after"}, busy, 0);
            chk({tag, "/epoch_hold"}, epoch_cnt, exp_ep);
        end else begin
            chk({tag, "/busy_after_stop"}, busy, 0);
            chk({tag, "/learn_after_stop"}, learn, 0);
            chk({tag, "/fwd_start_after_stop"}, fwd_start, 0);
            chk({tag, "/rd_en_after_stop"}, mem_rd_en, 0);
            if (mode == 1) begin
                chk({tag, "/epoch_hold"}, epoch_cnt, exp_ep);
                chk({tag, "/miss_hold"}, miss_cnt, exp_miss);
            end else begin
                chk({tag, "/epoch_clr"}, epoch_cnt, 0);
                chk({tag, "/miss_clr"}, miss_cnt, 0);
                chk({tag, "/x_clr"}, x_out, 0);
                chk({tag, "/err_clr"}, err, 0);
                chk({tag, "/addr_clr"}, mem_addr, 0);
            end
            act = 0;
            for (int i = 0; i < 8; i++) begin
                if (done || learn || fwd_start || mem_rd_en || busy) act++;
                tick();
            end
            chk({tag, "/quiet_after_stop"}, act, 0);
            chk({tag, "/timeout_after_stop"}, timeout, 0);
        end
    endtask

    initial begin
        int n, me, d, tries;
        rst = 1'b1; start = 1'b0; abort = 1'b0; learn_en = 1'b0;
        n_samples = '0; max_epochs = '0;
        mem_rd_data = '0; fwd_done = 1'b0; score = '0;
        rd_pend = 1'b0; rd_addr = '0; fwd_idx = 0; fwd_wait = -1; fwd_delay = 0;
        hang_k = -1; cur_score = 0; upd_now = 1'b0; cyc = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset state, with start and abort asserted to show reset wins
        start = 1'b1; abort = 1'b1;
        tick(); tick();
        chk("rst/busy", busy, 0);
        chk("rst/outputs", {mem_rd_en, fwd_start, learn, done, timeout}, 0);
        chk("rst/x_err", {x_out, err}, 0);
        chk("rst/counters", {epoch_cnt, miss_cnt, mem_addr}, 0);
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        tick();

        // start together with abort in IDLE is ignored
        n_samples = 5'd2; max_epochs = 8'd1;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("idle_abort_start/busy", busy, 0);
        tick();
        chk("idle_abort_start/rd_en", mem_rd_en, 0);

        // Zero samples goes straight to a done pulse
        n_samples = '0; max_epochs = 8'd3; learn_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_n/done", done, 1);
        chk("zero_n/rd_en", mem_rd_en, 0);
        tick();
        chk("zero_n/done_pulse", done, 0);
        chk("zero_n/busy", busy, 0);

        // Two confident correct samples, one epoch
        fill_mem(2);
        mem[0][16] = 1'b1; mem[1][16] = 1'b0;
        score_seq = '{40, -40};
        run_case("two_ok", 2, 1, 1'b1, 0, -1, 0);

        // Saturating errors in both directions
        score_seq = '{-200, 200};
        run_case("sat", 2, 1, 1'b1, 0, -1, 0);

        // Always wrong: every epoch runs until the limit
        fill_mem(1);
        fill_scores(12, -300, 0);
        run_case("always_miss", 3, 4, 1'b1, 0, -1, 0);

        // Forward pass never completes
        fill_scores(4, -50, 50);
        run_case("timeout", 3, 2, 1'b1, 0, 0, 0);

        // Abort while waiting in the second epoch
        fill_scores(12, -300, 0);
        run_case("abort", 3, 4, 1'b1, 0, 4, 1);

        // Reset in the update cycle of the third pass
        fill_mem(2);
        fill_scores(8, -100, 100);
        run_case("rst_mid", 4, 2, 1'b1, 0, 2, 2);

        // Evaluate only
        fill_mem(2);
        fill_scores(8, -100, 100);
        run_case("eval_only", 8, 1, 1'b0, 0, -1, 0);

        // Randomized runs with variable forward latency
        for (int t = 0; t < 6; t++) begin
            n = 1 + int'($urandom_range(15));
            me = 1 + int'($urandom_range(4));
            d = int'($urandom_range(2));
            fill_mem(2);
            tries = (t < 3) ? 40 : 400;
            fill_scores(n * me, -tries, tries);
            run_case($sformatf("rand%0d", t), n, me, 1'($urandom_range(1)), d, -1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
